// File: rtl/xhdmiout_tmds_encode.sv
// TMDS symbol encoder for one HDMI channel.
// Two-stage pipeline: stage 1 forms the transition-minimised q_m word and its
// ones count (plus the selections for the non-video periods); stage 2 applies
// DC balancing with the running disparity, or picks the fixed control, TERC4
// or guard-band code. o_word bit 0 is the first bit on the wire.
module xhdmiout_tmds_encode #(
   parameter int CHANNEL = 0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_mode,
   input  logic [7:0] i_data,
   input  logic [1:0] i_ctl,
   output logic [9:0] o_word
);

   localparam logic [1:0] MODE_CTL = 2'd0;
   localparam logic [1:0] MODE_VID = 2'd1;
   localparam logic [1:0] MODE_ISL = 2'd2;
   localparam logic [1:0] MODE_GRD = 2'd3;

   localparam logic [9:0] CTL_00  = 10'b1101010100;
   localparam logic [9:0] CTL_01  = 10'b0010101011;
   localparam logic [9:0] CTL_10  = 10'b0101010100;
   localparam logic [9:0] CTL_11  = 10'b1010101011;

   localparam logic [9:0] GUARD_A = 10'b1011001100;
   localparam logic [9:0] GUARD_B = 10'b0100110011;

   // Channel 1 uses the complementary video guard; any value other than
   // 1 or 2 (including out-of-range indices) behaves like channel 0.
   localparam logic [9:0] VID_GUARD = (CHANNEL == 1) ? GUARD_B : GUARD_A;
   localparam logic       ISL_FIXED = (CHANNEL == 1) || (CHANNEL == 2);

   // ------------------------------------------------------------------
   // Encoding helpers
   // ------------------------------------------------------------------
   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   // Transition-minimising stage: XNOR chaining when the byte is one-heavy.
   function automatic logic [8:0] tmds_qm(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n;
      n    = ones8(d);
      q    = 9'd0;
      q[0] = d[0];
      if ((n > 4'd4) || ((n == 4'd4) && !d[0])) begin
         for (int i = 1; i < 8; i++) begin
            q[i] = ~(q[i-1] ^ d[i]);
         end
         q[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) begin
            q[i] = q[i-1] ^ d[i];
         end
         q[8] = 1'b1;
      end
      return q;
   endfunction

   function automatic logic [9:0] terc4(input logic [3:0] n);
      logic [9:0] w;
      case (n)
         4'h0:    w = 10'b1010011100;
         4'h1:    w = 10'b1001100011;
         4'h2:    w = 10'b1011100100;
         4'h3:    w = 10'b1011100010;
         4'h4:    w = 10'b0101110001;
         4'h5:    w = 10'b0100011110;
         4'h6:    w = 10'b0110001110;
         4'h7:    w = 10'b0100111100;
         4'h8:    w = 10'b1011001100;
         4'h9:    w = 10'b0100111001;
         4'hA:    w = 10'b0110011100;
         4'hB:    w = 10'b1011000110;
         4'hC:    w = 10'b1010001110;
         4'hD:    w = 10'b1001110001;
         4'hE:    w = 10'b0101100011;
         default: w = 10'b1011000011;
      endcase
      return w;
   endfunction

   function automatic logic [9:0] ctl_code(input logic [1:0] c);
      logic [9:0] w;
      case (c)
         2'b00:   w = CTL_00;
         2'b01:   w = CTL_01;
         2'b10:   w = CTL_10;
         default: w = CTL_11;
      endcase
      return w;
   endfunction

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic [1:0]        mode_p1_d, mode_p1_q;
   logic [1:0]        ctl_p1_d,  ctl_p1_q;
   logic [3:0]        nib_p1_d,  nib_p1_q;
   logic              gsel_p1_d, gsel_p1_q;
   logic [8:0]        qm_p1_d,   qm_p1_q;
   logic [3:0]        n1_p1_d,   n1_p1_q;

   logic [9:0]        o_word_d,  o_word_q;
   logic signed [4:0] cnt_d,     cnt_q;

   // Stage 0 -> 1: capture the period selections and build q_m with its ones count
   always_comb begin
      mode_p1_d = i_mode;
      ctl_p1_d  = i_ctl;
      nib_p1_d  = i_data[3:0];
      gsel_p1_d = i_data[0];
      qm_p1_d   = tmds_qm(i_data);
      n1_p1_d   = ones8(qm_p1_d[7:0]);
   end

   // Stage 1 control: reset parks the pipe in control period, C1C0 = 00
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mode_p1_q <= MODE_CTL;
         ctl_p1_q  <= 2'b00;
      end else begin
         mode_p1_q <= mode_p1_d;
         ctl_p1_q  <= ctl_p1_d;
      end
   end

   // Stage 1 data: only consumed when the registered mode selects it
   always_ff @(posedge i_clk) begin
      nib_p1_q  <= nib_p1_d;
      gsel_p1_q <= gsel_p1_d;
      qm_p1_q   <= qm_p1_d;
      n1_p1_q   <= n1_p1_d;
   end

   // ------------------------------------------------------------------
   // Stage 1 -> 2: DC balancing for video, fixed code tables otherwise
   // ------------------------------------------------------------------
   logic signed [4:0] disp_qm;   // n1 - n0 of q_m[7:0]
   logic signed [4:0] two_q8;    // 2 * q_m[8]
   logic signed [4:0] two_nq8;   // 2 * ~q_m[8]
   logic              q8;

   // Stage-2 symbol selection and running-disparity update
   always_comb begin
      q8       = qm_p1_q[8];
      // 2*n1 - 8; the 5-bit wrap at n1 = 8 still yields +8
      disp_qm  = $signed({n1_p1_q, 1'b0}) - 5'sd8;
      two_q8   = q8 ? 5'sd2 : 5'sd0;
      two_nq8  = q8 ? 5'sd0 : 5'sd2;
      o_word_d = CTL_00;
      cnt_d    = 5'sd0;
      case (mode_p1_q)
         MODE_VID: begin
            if ((cnt_q == 5'sd0) || (n1_p1_q == 4'd4)) begin
               o_word_d = {~q8, q8, (q8 ? qm_p1_q[7:0] : ~qm_p1_q[7:0])};
               cnt_d    = q8 ? (cnt_q + disp_qm) : (cnt_q - disp_qm);
            end else if (((cnt_q > 5'sd0) && (n1_p1_q > 4'd4)) ||
                         ((cnt_q < 5'sd0) && (n1_p1_q < 4'd4))) begin
               o_word_d = {1'b1, q8, ~qm_p1_q[7:0]};
               cnt_d    = cnt_q + two_q8 - disp_qm;
            end else begin
               o_word_d = {1'b0, q8, qm_p1_q[7:0]};
               cnt_d    = cnt_q + disp_qm - two_nq8;
            end
         end
         MODE_ISL: begin
            o_word_d = terc4(nib_p1_q);
         end
         MODE_GRD: begin
            if (!gsel_p1_q) begin
               o_word_d = VID_GUARD;
            end else if (ISL_FIXED) begin
               o_word_d = GUARD_B;
            end else begin
               o_word_d = terc4({2'b11, ctl_p1_q});
            end
         end
         default: begin
            o_word_d = ctl_code(ctl_p1_q);
         end
      endcase
   end

   // Stage 2 registers: output symbol and disparity; reset drops any in-flight symbol
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_word_q <= CTL_00;
         cnt_q    <= 5'sd0;
      end else begin
         o_word_q <= o_word_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_word = o_word_q;

endmodule

// File: tb/tb_xhdmiout_tmds_encode.sv
// Self-checking bench for xhdmiout_tmds_encode: directed vector table,
// hand-written reset/guard sequences and a decoded random video stream.
module tb_xhdmiout_tmds_encode;

   localparam int NRAND = 10000;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [7:0] data;
   logic [1:0] ctl;
   logic [9:0] w0, w1, w2, w3;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] data;
      logic [1:0] ctl;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[$];

   xhdmiout_tmds_encode #(.CHANNEL(0)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data), .i_ctl(ctl), .o_word(w0));
   xhdmiout_tmds_encode #(.CHANNEL(1)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data), .i_ctl(ctl), .o_word(w1));
   xhdmiout_tmds_encode #(.CHANNEL(2)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data), .i_ctl(ctl), .o_word(w2));
   xhdmiout_tmds_encode #(.CHANNEL(3)) dut3 (
      .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_data(data), .i_ctl(ctl), .o_word(w3));

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c);
      mode = m;
      data = d;
      ctl  = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                          input logic [9:0] e);
      vec_t v;
      v.mode = m;
      v.data = d;
      v.ctl  = c;
      v.exp  = e;
      vecs.push_back(v);
   endtask

   // Reference DVI/HDMI video decoder
   function automatic logic [7:0] dvi_decode(input logic [9:0] w);
      logic [7:0] q;
      logic [7:0] d;
      q    = w[9] ? ~w[7:0] : w[7:0];
      d    = 8'd0;
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
      return d;
   endfunction

   function automatic int word_disp(input logic [9:0] w);
      return 2 * $countones(w) - 10;
   endfunction

   logic [9:0] terc_exp [16];

   initial begin
      terc_exp[0]  = 10'b1010011100;  terc_exp[1]  = 10'b1001100011;
      terc_exp[2]  = 10'b1011100100;  terc_exp[3]  = 10'b1011100010;
      terc_exp[4]  = 10'b0101110001;  terc_exp[5]  = 10'b0100011110;
      terc_exp[6]  = 10'b0110001110;  terc_exp[7]  = 10'b0100111100;
      terc_exp[8]  = 10'b1011001100;  terc_exp[9]  = 10'b0100111001;
      terc_exp[10] = 10'b0110011100;  terc_exp[11] = 10'b1011000110;
      terc_exp[12] = 10'b1010001110;  terc_exp[13] = 10'b1001110001;
      terc_exp[14] = 10'b0101100011;  terc_exp[15] = 10'b1011000011;

      // control codes
      add_vec(2'd0, 8'h5A, 2'b00, 10'b1101010100);
      add_vec(2'd0, 8'hA5, 2'b01, 10'b0010101011);
      add_vec(2'd0, 8'h00, 2'b10, 10'b0101010100);
      add_vec(2'd0, 8'hFF, 2'b11, 10'b1010101011);
      // TERC4 sweep with junk in the upper nibble and ctl
      for (int k = 0; k < 16; k++) begin
         add_vec(2'd2, {4'hA, 4'(k)}, 2'(k), terc_exp[k]);
      end
      // channel-0 guards
      add_vec(2'd3, 8'h00, 2'b10, 10'b1011001100);
      add_vec(2'd3, 8'h01, 2'b10, 10'b0101100011);
      add_vec(2'd3, 8'h01, 2'b00, 10'b1010001110);
      // video with hand-tracked disparity
      add_vec(2'd1, 8'h00, 2'b00, 10'b0100000000);  // cnt -8
      add_vec(2'd1, 8'h00, 2'b00, 10'b1111111111);  // cnt  2
      add_vec(2'd1, 8'hFF, 2'b00, 10'b1000000000);  // cnt -6
      add_vec(2'd1, 8'h55, 2'b00, 10'b0100110011);  // cnt -6
      add_vec(2'd0, 8'h00, 2'b00, 10'b1101010100);  // cnt forced 0
      add_vec(2'd1, 8'h00, 2'b00, 10'b0100000000);  // cnt -8
      add_vec(2'd1, 8'hFF, 2'b00, 10'b0011111111);  // cnt -2
      add_vec(2'd1, 8'h01, 2'b00, 10'b0111111111);  // cnt  6
      add_vec(2'd1, 8'h01, 2'b00, 10'b1100000000);  // cnt  0
      add_vec(2'd1, 8'h01, 2'b00, 10'b0111111111);  // cnt  8

      // ---------------- reset and first symbols ----------------
      rst = 1'b1;
      drive(2'd0, 8'h00, 2'b01);
      tick();
      tick();
      check("reset_state_ch0", w0, 10'b1101010100);
      check("reset_state_ch1", w1, 10'b1101010100);
      rst = 1'b0;
      tick();
      check("post_reset_edge1", w0, 10'b1101010100);
      tick();
      check("post_reset_edge2", w0, 10'b0010101011);

      // ---------------- vector table ----------------
      for (int i = 0; i <= vecs.size(); i++) begin
         if (i < vecs.size()) drive(vecs[i].mode, vecs[i].data, vecs[i].ctl);
         else                 drive(2'd0, 8'h00, 2'b00);
         tick();
         if (i >= 1) check($sformatf("vec%0d", i - 1), w0, vecs[i-1].exp);
      end

      // ---------------- guard codes on every channel ----------------
      drive(2'd3, 8'h00, 2'b10);
      tick();
      drive(2'd3, 8'h01, 2'b10);
      tick();
      check("vguard_ch0", w0, 10'b1011001100);
      check("vguard_ch1", w1, 10'b0100110011);
      check("vguard_ch2", w2, 10'b1011001100);
      check("vguard_ch3", w3, 10'b1011001100);
      drive(2'd0, 8'h00, 2'b00);
      tick();
      check("iguard_ch0", w0, 10'b0101100011);
      check("iguard_ch1", w1, 10'b0100110011);
      check("iguard_ch2", w2, 10'b0100110011);
      check("iguard_ch3", w3, 10'b0101100011);

      // ---------------- reset in the middle of video ----------------
      drive(2'd1, 8'h00, 2'b00);
      tick();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("midreset_out", w0, 10'b1101010100);
      rst = 1'b0;
      tick();
      check("restart_flush", w0, 10'b1101010100);
      tick();
      check("restart_vid0", w0, 10'b0100000000);
      tick();
      check("restart_vid1", w0, 10'b1111111111);

      // ---------------- random video stream ----------------
      drive(2'd0, 8'h00, 2'b00);
      tick();
      tick();
      begin
         logic [7:0] prev_b;
         int         cum;
         prev_b = 8'h00;
         cum    = 0;
         for (int j = 0; j <= NRAND; j++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (j < NRAND) drive(2'd1, b, 2'b00);
            else           drive(2'd0, 8'h00, 2'b00);
            tick();
            if (j >= 1) begin
               check($sformatf("rand_decode%0d", j - 1), {2'b00, dvi_decode(w0)}, {2'b00, prev_b});
               cum = cum + word_disp(w0);
               checks++;
               if ((cum > 18) || (cum < -18)) begin
                  failures++;
                  $display("FAIL rand_disparity%0d cum=%0d limit=+-18", j - 1, cum);
               end
            end
            prev_b = b;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
